// File: rtl/euclid_key_solver_if.sv
// Handshake and data bundle between a syndrome source and euclid_key_solver.
// The master drives START/SYN; the solver (slave) returns the key-equation results.
interface euclid_key_solver_if #(
  parameter int M = 4,
  parameter int T = 2
);
  logic                       START;
  logic [2*T*M-1:0]           SYN;
  logic                       BUSY;
  logic                       DONE;
  logic [(T+1)*M-1:0]         LAMBDA;
  logic [T*M-1:0]             OMEGA;
  logic [$clog2(T+1):0]       DEG_LAMBDA;
  logic                       FAIL;

  modport master (
    output START, SYN,
    input  BUSY, DONE, LAMBDA, OMEGA, DEG_LAMBDA, FAIL
  );

  modport slave (
    input  START, SYN,
    output BUSY, DONE, LAMBDA, OMEGA, DEG_LAMBDA, FAIL
  );
endinterface

// File: rtl/euclid_key_solver.sv
// Euclidean key-equation solver over GF(2^M): syndromes in, error locator/evaluator out.
// Define EUCLID_NORMALIZE_EN to add a NORM cycle that scales the results so Lambda0 = 1.
module euclid_key_solver #(
  parameter int         M         = 4,
  parameter int         T         = 2,
  parameter logic [M:0] PRIM_POLY = 5'b10011
) (
  input logic                CLK,
  input logic                RESET,
  euclid_key_solver_if.slave bus
);
  localparam int NA = 2*T + 1;
  localparam int NB = 2*T;
  localparam int NL = T + 1;
  localparam int CW = $clog2(2*T + 3);
  localparam int DW = $clog2(T + 1) + 1;

  typedef logic [M-1:0] sym_t;
  typedef enum logic [1:0] {IDLE, STEP, NORM, FIN} state_e;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p = '0;
    sym_t s = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p ^= s;
      s = {s[M-2:0], 1'b0} ^ (s[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
    return p;
  endfunction

  // a^(2^M - 2) built from repeated squaring; yields 0 for a = 0.
  function automatic sym_t gf_inv(sym_t a);
    sym_t r = sym_t'(1);
    sym_t s = a;
    for (int k = 1; k < M; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [NA-1:0][M-1:0]  a_q, a_d;
  logic [NB-1:0][M-1:0]  b_q, b_d;
  logic [NL-1:0][M-1:0]  la_q, la_d;
  logic [NL-1:0][M-1:0]  lb_q, lb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NL-1:0][M-1:0]  lambda_q, lambda_d;
  logic [T-1:0][M-1:0]   omega_q, omega_d;
  logic [DW-1:0]         deg_lambda_q, deg_lambda_d;
  logic                  fail_q, fail_d;

  int                    deg_a, deg_b, deg_an, deg_lb, shift;
  sym_t                  lead_a, lead_b, q;
  logic [NB-1:0][M-1:0]  qb;
  logic [NL-1:0][M-1:0]  qlb;
  logic [NA-1:0][M-1:0]  a_n;
  logic [NL-1:0][M-1:0]  la_n;
  logic [DW-1:0]         deg_lb_v;

  // One division step: A' = A + q*x^d*B and LA' = LA + q*x^d*LB.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    deg_a  = -1;
    deg_b  = -1;
    deg_lb = -1;
    deg_an = -1;
    lead_a = '0;
    lead_b = '0;
    for (int i = 0; i < NA; i++) if (a_q[i] != '0) begin deg_a = i; lead_a = a_q[i]; end
    for (int i = 0; i < NB; i++) if (b_q[i] != '0) begin deg_b = i; lead_b = b_q[i]; end
    for (int i = 0; i < NL; i++) if (lb_q[i] != '0) deg_lb = i;
    deg_lb_v = (deg_lb < 0) ? '0 : DW'(deg_lb);

    q     = gf_mul(lead_a, gf_inv(lead_b));
    shift = deg_a - deg_b;
    for (int j = 0; j < NB; j++) qb[j]  = gf_mul(q, b_q[j]);
    for (int j = 0; j < NL; j++) qlb[j] = gf_mul(q, lb_q[j]);

    a_n = a_q;
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NB; j++)
        if (j + shift == i) a_n[i] ^= qb[j];
    la_n = la_q;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++)
        if (j + shift == i) la_n[i] ^= qlb[j];
    for (int i = 0; i < NA; i++) if (a_n[i] != '0) deg_an = i;
  end

`ifdef EUCLID_NORMALIZE_EN
  sym_t l0_inv;
  assign l0_inv = gf_inv(lb_q[0]);
`endif

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    la_d         = la_q;
    lb_d         = lb_q;
    cnt_d        = cnt_q;
    lambda_d     = lambda_q;
    omega_d      = omega_q;
    deg_lambda_d = deg_lambda_q;
    fail_d       = fail_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          a_d        = '0;
          a_d[NA-1]  = sym_t'(1);
          b_d        = bus.SYN;
          la_d       = '0;
          lb_d       = '0;
          lb_d[0]    = sym_t'(1);
          cnt_d      = '0;
          state_d    = STEP;
        end
      end
      STEP: begin
        if (deg_b < T) begin
`ifdef EUCLID_NORMALIZE_EN
          state_d      = NORM;
`else
          lambda_d     = lb_q;
          omega_d      = b_q[T-1:0];
          deg_lambda_d = deg_lb_v;
          fail_d       = (lb_q[0] == '0);
          state_d      = FIN;
`endif
        end else if (cnt_q == CW'(2*T + 2)) begin
          lambda_d     = lb_q;
          omega_d      = b_q[T-1:0];
          deg_lambda_d = deg_lb_v;
          fail_d       = 1'b1;
          state_d      = FIN;
        end else begin
          if (deg_an < deg_b) begin
            // deg(A') < deg(B) <= 2T-1, so A' fits in the divisor register.
            a_d          = '0;
            a_d[NB-1:0]  = b_q;
            b_d          = a_n[NB-1:0];
            la_d         = lb_q;
            lb_d         = la_n;
          end else begin
            a_d  = a_n;
            la_d = la_n;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef EUCLID_NORMALIZE_EN
      NORM: begin
        for (int i = 0; i < NL; i++)
          lambda_d[i] = (lb_q[0] != '0) ? gf_mul(lb_q[i], l0_inv) : lb_q[i];
        for (int i = 0; i < T; i++)
          omega_d[i] = (lb_q[0] != '0) ? gf_mul(b_q[i], l0_inv) : b_q[i];
        deg_lambda_d = deg_lb_v;
        fail_d       = (lb_q[0] == '0);
        state_d      = FIN;
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      la_q         <= '0;
      lb_q         <= '0;
      cnt_q        <= '0;
      lambda_q     <= '0;
      omega_q      <= '0;
      deg_lambda_q <= '0;
      fail_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      la_q         <= la_d;
      lb_q         <= lb_d;
      cnt_q        <= cnt_d;
      lambda_q     <= lambda_d;
      omega_q      <= omega_d;
      deg_lambda_q <= deg_lambda_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.BUSY       = (state_q != IDLE);
  assign bus.DONE       = (state_q == FIN);
  assign bus.LAMBDA     = lambda_q;
  assign bus.OMEGA      = omega_q;
  assign bus.DEG_LAMBDA = deg_lambda_q;
  assign bus.FAIL       = fail_q;
endmodule

// File: tb/tb_euclid_key_solver.sv
// Directed bench for euclid_key_solver, M=4, T=2, GF(16) with x^4 + x + 1.
// Expected values follow the build: EUCLID_NORMALIZE_EN adds one cycle and normalised results.
module tb_euclid_key_solver;
  localparam int M = 4;
  localparam int T = 2;
`ifdef EUCLID_NORMALIZE_EN
  localparam int          NX        = 1;
  localparam logic [11:0] P1_LAMBDA = 12'h021;
  localparam logic [7:0]  P1_OMEGA  = 8'h02;
`else
  localparam int          NX        = 0;
  localparam logic [11:0] P1_LAMBDA = 12'h0E7;
  localparam logic [7:0]  P1_OMEGA  = 8'h0E;
`endif
  localparam logic [15:0] SYN_ZERO = 16'h0000;
  localparam logic [15:0] SYN_POS0 = 16'h1111;
  localparam logic [15:0] SYN_POS1 = 16'h3842;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;
  int   d0;
  int   lat;

  euclid_key_solver_if #(.M(M), .T(T)) bus ();

  euclid_key_solver #(.M(M), .T(T), .PRIM_POLY(5'b10011)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.DONE) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_solve(input logic [15:0] syn);
    bus.START = 1'b1;
    bus.SYN   = syn;
    tick();
    bus.START = 1'b0;
  endtask

  // Called at the negedge of cycle N+first; returns k such that DONE is high in cycle N+k.
  task automatic wait_done(input string tag, input int first, output int k);
    k = first;
    while (!bus.DONE && k < 40) begin
      tick();
      k++;
    end
    if (!bus.DONE) check({tag, "_done_timeout"}, bus.DONE, 1);
  endtask

  task automatic check_result(input string tag, input int k, input int exp_k,
                              input logic [11:0] lam, input logic [7:0] om,
                              input logic [2:0] deg, input logic fl);
    check({tag, "_latency"}, k, exp_k);
    check({tag, "_busy_at_done"}, bus.BUSY, 1);
    check({tag, "_lambda"}, bus.LAMBDA, lam);
    check({tag, "_omega"}, bus.OMEGA, om);
    check({tag, "_deg"}, bus.DEG_LAMBDA, deg);
    check({tag, "_fail"}, bus.FAIL, fl);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, bus.BUSY, 0);
    check({tag, "_done"}, bus.DONE, 0);
    check({tag, "_lambda"}, bus.LAMBDA, 0);
    check({tag, "_omega"}, bus.OMEGA, 0);
    check({tag, "_deg"}, bus.DEG_LAMBDA, 0);
    check({tag, "_fail"}, bus.FAIL, 0);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.SYN   = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    check_cleared("reset");
    rst_n = 1'b1;
    tick();

    // All-zero syndromes terminate at the first STEP.
    start_solve(SYN_ZERO);
    check("zero_busy_after_start", bus.BUSY, 1);
    wait_done("zero", 1, lat);
    check_result("zero", lat, 2 + NX, 12'h001, 8'h00, 3'd0, 1'b0);
    tick();
    check("zero_done_pulse", bus.DONE, 0);
    check("zero_idle_after", bus.BUSY, 0);

    // Single error at position 0; old results hold while solving.
    start_solve(SYN_POS0);
    check("pos0_hold_lambda", bus.LAMBDA, 12'h001);
    wait_done("pos0", 1, lat);
    check_result("pos0", lat, 4 + NX, 12'h011, 8'h01, 3'd1, 1'b0);
    tick();

    // Single error at position 1 with extra STARTs at N+1 and N+2 and SYN changing.
    d0 = done_seen;
    start_solve(SYN_POS1);
    bus.START = 1'b1;
    bus.SYN   = SYN_POS0;
    tick();
    tick();
    bus.START = 1'b0;
    bus.SYN   = '0;
    wait_done("pos1", 3, lat);
    check_result("pos1", lat, 4 + NX, P1_LAMBDA, P1_OMEGA, 3'd1, 1'b0);

    // START in the DONE cycle is ignored; held into the next cycle it is accepted.
    bus.START = 1'b1;
    bus.SYN   = SYN_POS0;
    tick();
    check("start_at_done_ignored", bus.BUSY, 0);
    check("pos1_single_done", done_seen - d0, 1);
    start_solve(SYN_POS0);
    wait_done("b2b", 1, lat);
    check_result("b2b", lat, 4 + NX, 12'h011, 8'h01, 3'd1, 1'b0);
    tick();

    // Reset mid-solve aborts with no DONE and clears outputs.
    start_solve(SYN_POS1);
    tick();
    rst_n = 1'b0;
    d0    = done_seen;
    tick();
    check_cleared("midreset");
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("midreset_no_done", done_seen - d0, 0);
    start_solve(SYN_POS1);
    wait_done("after_reset", 1, lat);
    check_result("after_reset", lat, 4 + NX, P1_LAMBDA, P1_OMEGA, 3'd1, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
